// File: rtl/da_fir_pkg.sv
// Shared types and helpers for the bit-serial distributed-arithmetic FIR.
package da_fir_pkg;

  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  typedef struct packed {
    logic                    clipped;
    logic signed [SAT_W-1:0] value;
  } sat_t;

  // Full-precision accumulator width: product width plus tap-count growth.
  function automatic int unsigned acc_width(input int unsigned taps,
                                            input int unsigned data_w,
                                            input int unsigned coef_w);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Clamp a signed value to the range of a width-bit two's-complement number.
  function automatic sat_t sat(input logic signed [SAT_W-1:0] value,
                               input int unsigned width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t res;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      res.clipped = 1'b1;
      res.value   = hi;
    end else if (value < lo) begin
      res.clipped = 1'b1;
      res.value   = lo;
    end else begin
      res.clipped = 1'b0;
      res.value   = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/da_fir_serial_lut.sv
// Combinational DA partial sum: adds every coefficient whose address bit is set.
module da_lut_sum #(
  parameter int unsigned TAPS   = 4,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 18
) (
  input  logic [TAPS-1:0]        addr,
  input  logic [TAPS*COEF_W-1:0] coefs,
  output logic [ACC_W-1:0]       sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (addr[i]) begin
        sum = sum + ACC_W'($signed(coefs[i*COEF_W +: COEF_W]));
      end
    end
  end

endmodule

// File: rtl/da_fir_serial.sv
// Bit-serial DA FIR: one sample per DATA_W compute cycles, saturated result on valid/ready.
module da_fir_serial
  import da_fir_pkg::*;
#(
  parameter int unsigned TAPS      = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COEF_W    = 8,
  parameter int unsigned OUT_W     = 10,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    coef_busy,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_sat
);

  localparam int unsigned ACC_W = acc_width(TAPS, DATA_W, COEF_W);
  localparam int unsigned KW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DATA_W - 1);

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] x [TAPS];
  logic [COEF_W-1:0] h [TAPS];
  logic [KW-1:0]     k;
  logic [ACC_W-1:0]  acc;

  logic                    accept;
  logic                    last;
  logic                    release_out;
  logic                    line_open;
  logic [TAPS-1:0]         plane;
  logic [TAPS*COEF_W-1:0]  coef_vec;
  logic [ACC_W-1:0]        lut_sum;
  logic [ACC_W-1:0]        shifted;
  logic [ACC_W-1:0]        acc_nxt;
  logic signed [ACC_W-1:0] acc_scaled;
  sat_t                    sat_res;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    last        = 1'b0;
    release_out = 1'b0;
    line_open   = 1'b0;
    case (state)
      IDLE: begin
        line_open = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (k == K_LAST) begin
          last      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        line_open = 1'b1;
        if (out_ready) begin
          release_out = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-plane address and flattened coefficient vector for the LUT adder.
  always_comb begin
    plane    = '0;
    coef_vec = '0;
    for (int i = 0; i < TAPS; i++) begin
      plane[i]                      = x[i][k];
      coef_vec[i*COEF_W +: COEF_W]  = h[i];
    end
  end

  da_lut_sum #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_lut (
    .addr  (plane),
    .coefs (coef_vec),
    .sum   (lut_sum)
  );

  // The top bit-plane carries negative weight in two's complement.
  always_comb begin
    shifted    = lut_sum << k;
    acc_nxt    = last ? (acc - shifted) : (acc + shifted);
    acc_scaled = $signed(acc_nxt) >>> OUT_SHIFT;
    sat_res    = sat(SAT_W'(acc_scaled), OUT_W);
  end

  // Delay line and coefficient registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = 1; i < TAPS; i++) begin
          x[i] <= flush ? '0 : x[i-1];
        end
        x[0] <= in_data;
      end else if (flush && line_open) begin
        for (int i = 0; i < TAPS; i++) begin
          x[i] <= '0;
        end
      end
      if (coef_we && line_open && (32'(coef_addr) < TAPS)) begin
        h[coef_addr] <= coef_data;
      end
    end
  end

  // Accumulator, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      k         <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      coef_busy <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      coef_busy <= (state_nxt == COMPUTE);
      if (accept) begin
        acc <= '0;
        k   <= '0;
      end else if (state == COMPUTE) begin
        acc <= acc_nxt;
        k   <= k + KW'(1);
      end
      if (last) begin
        out_data  <= OUT_W'(sat_res.value);
        out_sat   <= sat_res.clipped;
        out_valid <= 1'b1;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_da_fir_serial.sv
// Randomised scoreboard bench for da_fir_serial with three output-shift variants.
module tb_da_fir_serial;

  localparam int TAPS = 4;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int OW   = 10;
  localparam int NSH  = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [CW-1:0] coef_data;
  logic          flush;
  logic          out_ready;

  logic          ir [NSH];
  logic          cb [NSH];
  logic          ov [NSH];
  logic [OW-1:0] od [NSH];
  logic          os [NSH];

  always #5 clk = ~clk;

  da_fir_serial #(.TAPS(TAPS), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(cb[0]),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_sat(os[0]));

  da_fir_serial #(.TAPS(TAPS), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .OUT_SHIFT(7)) dut_sh7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(cb[1]),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_sat(os[1]));

  da_fir_serial #(.TAPS(TAPS), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .OUT_SHIFT(8)) dut_sh8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(cb[2]),
    .flush(flush), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_sat(os[2]));

  typedef struct {
    int   t;
    int   y [NSH];
    logic s [NSH];
  } exp_t;

  exp_t q [$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   xs [TAPS];
  int   hs [TAPS];
  int   busy_cnt = 0;
  logic holding  = 1'b0;
  logic seen     = 1'b0;
  int   shifts [NSH] = '{0, 7, 8};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void clampv(input int s, input int sh, output int y, output logic f);
    int v;
    v = s >>> sh;
    if (v > 511) begin
      y = 511; f = 1'b1;
    end else if (v < -512) begin
      y = -512; f = 1'b1;
    end else begin
      y = v; f = 1'b0;
    end
  endfunction

  // Reference model: y = sum h[i]*x[i], evaluated at each accept edge.
  initial begin
    for (int i = 0; i < TAPS; i++) begin xs[i] = 0; hs[i] = 0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < TAPS; i++) begin xs[i] = 0; hs[i] = 0; end
        busy_cnt = 0;
        holding  = 1'b0;
        q.delete();
      end else begin
        logic was_busy, was_hold, acc;
        cyc++;
        was_busy = (busy_cnt != 0);
        was_hold = holding;
        acc      = in_valid && !was_busy && !was_hold;
        if (!was_busy) begin
          if (coef_we && int'(coef_addr) < TAPS) hs[coef_addr] = int'($signed(coef_data));
          if (flush) for (int i = 0; i < TAPS; i++) xs[i] = 0;
        end
        if (acc) begin
          exp_t e;
          int sum;
          for (int i = TAPS - 1; i > 0; i--) xs[i] = xs[i-1];
          xs[0] = int'($signed(in_data));
          sum = 0;
          for (int i = 0; i < TAPS; i++) sum += hs[i] * xs[i];
          e.t = cyc;
          for (int j = 0; j < NSH; j++) clampv(sum, shifts[j], e.y[j], e.s[j]);
          q.push_back(e);
          busy_cnt = DW;
        end else if (was_busy) begin
          busy_cnt--;
          if (busy_cnt == 0) holding = 1'b1;
        end
        if (was_hold && out_ready) holding = 1'b0;
      end
    end
  end

  // Monitor: handshake flags every cycle, results popped on first sight of out_valid.
  always @(negedge clk) begin
    chk("in_ready", int'(ir[0]), int'(busy_cnt == 0 && !holding));
    chk("coef_busy", int'(cb[0]), int'(busy_cnt != 0));
    chk("out_valid", int'(ov[0]), int'(holding));
    if (!rst_n) seen = 1'b0;
    if (ov[0]) begin
      if (!seen) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got out_data %0d expected no result", $signed(od[0]));
        end else begin
          cur = q.pop_front();
          chk("latency", cyc - cur.t, DW);
        end
        seen = 1'b1;
      end
      for (int j = 0; j < NSH; j++) begin
        chk($sformatf("out_data_sh%0d", shifts[j]), int'($signed(od[j])), cur.y[j]);
        chk($sformatf("out_sat_sh%0d", shifts[j]), int'(os[j]), int'(cur.s[j]));
      end
      if (out_ready) seen = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we = 1'b1; coef_addr = 2'(a); coef_data = CW'(d);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int v);
    int n;
    in_valid = 1'b1; in_data = DW'(v); n = 0;
    while (!ir[0] && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((!ir[0] || ov[0]) && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 200 cycles");
    end
  endtask

  initial begin
    int n;
    in_valid = 0; in_data = '0; coef_we = 0; coef_addr = '0; coef_data = '0;
    flush = 0; out_ready = 1;
    repeat (3) tick();
    chk("reset_out_data", int'(od[0]), 0);
    chk("reset_out_sat", int'(os[0]), 0);
    rst_n = 1'b1;
    tick();

    // Impulse response
    wcoef(0, 1); wcoef(1, 2); wcoef(2, 3); wcoef(3, 4);
    foreach (shifts[j]) begin end
    send(1); wait_idle();
    for (int i = 0; i < 4; i++) begin send(0); wait_idle(); end

    // Signed extremes
    for (int i = 0; i < TAPS; i++) wcoef(i, -128);
    for (int i = 0; i < 4; i++) begin send(-128); wait_idle(); end

    // Backpressure with a pending sample
    out_ready = 1'b0;
    send(77);
    in_valid = 1'b1; in_data = DW'(-3);
    repeat (20) tick();
    out_ready = 1'b1;
    send(-3); wait_idle();

    // Coefficient write ignored in COMPUTE, honoured in HOLD
    wcoef(0, 2); wcoef(1, 0); wcoef(2, 0); wcoef(3, 0);
    in_valid = 1'b1; in_data = DW'(9);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    wcoef(0, 5);
    out_ready = 1'b0;
    n = 0;
    while (!ov[0] && n < 50) begin tick(); n++; end
    wcoef(0, 5);
    out_ready = 1'b1;
    flush = 1'b1;
    send(1);
    flush = 1'b0;
    wait_idle();

    // Flush in IDLE
    for (int i = 0; i < TAPS; i++) wcoef(i, 1);
    for (int i = 0; i < 3; i++) begin send(1); wait_idle(); end
    flush = 1'b1; tick(); flush = 1'b0;
    send(2); wait_idle();

    // Reset in the middle of COMPUTE
    in_valid = 1'b1; in_data = DW'(5);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", int'(ov[0]), 0);
    chk("rst_mid_in_ready", int'(ir[0]), 1);
    tick();
    rst_n = 1'b1;
    tick();
    send(1); wait_idle();

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = DW'($urandom);
      coef_we   = ($urandom_range(0, 5) == 0);
      coef_addr = 2'($urandom);
      coef_data = CW'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 0; coef_we = 0; flush = 0; out_ready = 1;
    wait_idle();
    tick();
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
